// File: rtl/lsu_mem_master_pkg.sv
// ---------------------------------------------------------------------------
// lsu_mem_master_pkg
// Shared definitions for the load/store unit memory master:
//   - FSM state encodings (IDLE / ACCESS / RESP)
//   - RV64 load/store funct3 encodings
//   - captured-request record
//   - access-size helpers (lane strobe, misalignment test)
// ---------------------------------------------------------------------------
package lsu_mem_master_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  // Fields of an accepted request still needed after the handshake.
  typedef struct packed {
    logic [2:0] funct3;
    logic [2:0] lane;
  } lsu_cap_t;

  // Byte-lane enables for an access of 1<<sz bytes starting at byte lane.
  function automatic logic [7:0] lane_strobe(input logic [1:0] sz, input logic [2:0] lane);
    logic [7:0] mask;
    case (sz)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      2'd3:    mask = 8'hFF;
      default: mask = 8'h00;
    endcase
    return mask << lane;
  endfunction

  // True when lane is not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] lane);
    logic mis;
    case (sz)
      2'd0:    mis = 1'b0;
      2'd1:    mis = lane[0];
      2'd2:    mis = |lane[1:0];
      2'd3:    mis = |lane;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_master_if
// Request/response handshake with the execute stage plus the 64-bit
// little-endian data-memory bus.
//   master : the LSU (accepts requests, drives memory strobes)
//   slave  : the environment (execute stage + memory)
// ---------------------------------------------------------------------------
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_wstrb;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        mem_ready;

  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, read_data, mem_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_read, mem_write, mem_wstrb, write_data
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, read_data, mem_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_read, mem_write, mem_wstrb, write_data
  );
endinterface

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data extraction: shifts the addressed byte lane down to
// bit 0, truncates to the access size and sign/zero-extends to 64 bits.
// Ports:
//   read_data  in  64  memory doubleword (byte k at [8k+7:8k])
//   lane       in  3   byte offset within the doubleword
//   funct3     in  3   load type
//   result     out 64  extended load value (0 for the illegal encoding)
// ---------------------------------------------------------------------------
module lsu_load_align
  import lsu_mem_master_pkg::*;
(
  input  logic [63:0] read_data,
  input  logic [2:0]  lane,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] shifted_s;

  // Lane shift then size-dependent extension.
  always_comb begin
    shifted_s = read_data >> {lane, 3'b000};
    result    = 64'd0;
    case (funct3)
      F3_B:    result = {{56{shifted_s[7]}},  shifted_s[7:0]};
      F3_H:    result = {{48{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    result = {{32{shifted_s[31]}}, shifted_s[31:0]};
      F3_D:    result = shifted_s;
      F3_BU:   result = {56'd0, shifted_s[7:0]};
      F3_HU:   result = {48'd0, shifted_s[15:0]};
      F3_WU:   result = {32'd0, shifted_s[31:0]};
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
// Load/store unit memory initiator. Accepts one request per handshake in
// IDLE, performs a doubleword-aligned access (ACCESS), then pulses a
// response for one cycle (RESP). Misaligned/illegal requests skip memory.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset
//   bus    lsu_mem_master_if.master (request, response and memory signals)
// Parameters:
//   TIMEOUT_CYC  ACCESS cycles without mem_ready before abort
// Configuration macro:
//   LSU_TIMEOUT_EN  enables the ACCESS timeout counter; without it ACCESS
//                   waits indefinitely for mem_ready.
// ---------------------------------------------------------------------------
module lsu_mem_master
  import lsu_mem_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  lsu_mem_master_if.master   bus
);

  logic [1:0]  state_r;
  lsu_cap_t    cap_r;
  logic        req_ready_r;
  logic        resp_valid_r;
  logic [63:0] resp_rdata_r;
  logic        resp_err_r;
  logic [63:0] mem_addr_r;
  logic        mem_read_r;
  logic        mem_write_r;
  logic [7:0]  mem_wstrb_r;
  logic [63:0] write_data_r;

  logic        accept_s;
  logic        req_err_s;
  logic [7:0]  store_strb_s;
  logic [63:0] store_shift_s;
  logic [63:0] load_ext_s;
  logic        tmo_hit_s;

  // Request decode: handshake, legality and store lane alignment.
  always_comb begin
    accept_s      = bus.req_valid && req_ready_r;
    req_err_s     = misaligned(bus.req_funct3[1:0], bus.req_addr[2:0]) ||
                    (bus.req_funct3 == F3_BAD) ||
                    (bus.req_store && bus.req_funct3[2]);
    store_strb_s  = lane_strobe(bus.req_funct3[1:0], bus.req_addr[2:0]);
    store_shift_s = bus.req_wdata << {bus.req_addr[2:0], 3'b000};
  end

  lsu_load_align u_load_align (
    .read_data (bus.read_data),
    .lane      (cap_r.lane),
    .funct3    (cap_r.funct3),
    .result    (load_ext_s)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_r;

  // Terminal count is reached during the TIMEOUT_CYC-th ACCESS cycle.
  assign tmo_hit_s = (tmo_cnt_r == CNT_W'(TIMEOUT_CYC - 1));

  // ACCESS cycle counter, cleared whenever a request is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= '0;
    end else if (accept_s) begin
      tmo_cnt_r <= '0;
    end else if (state_r == ST_ACCESS) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign tmo_hit_s = 1'b0;
`endif

  // Main FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cap_r        <= '0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 64'd0;
      resp_err_r   <= 1'b0;
      mem_addr_r   <= 64'd0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_wstrb_r  <= 8'd0;
      write_data_r <= 64'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cap_r       <= '{funct3: bus.req_funct3, lane: bus.req_addr[2:0]};
            req_ready_r <= 1'b0;
            if (req_err_s) begin
              // Illegal request: answer immediately, memory untouched.
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 64'd0;
            end else begin
              state_r      <= ST_ACCESS;
              mem_addr_r   <= {bus.req_addr[63:3], 3'b000};
              mem_read_r   <= !bus.req_store;
              mem_write_r  <= bus.req_store;
              mem_wstrb_r  <= bus.req_store ? store_strb_s : 8'd0;
              write_data_r <= bus.req_store ? store_shift_s : 64'd0;
            end
          end
        end
        ST_ACCESS: begin
          // mem_ready wins over a simultaneous terminal count.
          if (bus.mem_ready || tmo_hit_s) begin
            state_r      <= ST_RESP;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_wstrb_r  <= 8'd0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= !bus.mem_ready;
            resp_rdata_r <= (bus.mem_ready && mem_read_r) ? load_ext_s : 64'd0;
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 64'd0;
        end
        default: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 64'd0;
          mem_read_r   <= 1'b0;
          mem_write_r  <= 1'b0;
          mem_wstrb_r  <= 8'd0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_read   = mem_read_r;
  assign bus.mem_write  = mem_write_r;
  assign bus.mem_wstrb  = mem_wstrb_r;
  assign bus.write_data = write_data_r;

endmodule
